bytes_to_dibits: RTL and testbench
==================================

# bytes_to_dibits

Byte-to-dibit serializer for the RMII transmit path, with an integrated running Ethernet CRC-32 over the emitted dibits. Each accepted byte becomes four dibits on consecutive clocks, LSB dibit first. The end-of-stream marker passes through once the last byte has drained. It sits between byte sources (ROM/RAM readers, packet synth) and the RMII TX pins, and feeds the FCS into the packet synthesizer.

## Interface
- BYTE_LEN, 8, byte width; fixed at 8 and taken from the shared package.
- clk  in  1  system clock (50 MHz RMII reference domain).
- reset  in  1  reset; asynchronous and active-low.
- inclk  in  1  one-cycle strobe: `in` holds a valid byte.
- in  in  8  byte to serialize.
- done_in  in  1  one-cycle strobe: end of stream.
- out  out  2  current dibit; valid when outclk=1.
- outclk  out  1  high for each cycle a dibit is presented.
- idle  out  1  high when the serializer holds no byte in progress.
- done_out  out  1  one-cycle strobe after the last dibit of the stream.
- crc  out  32  running Ethernet FCS over dibits emitted since frame start.

## Operation
- Shifter: 8-bit shift register plus 2-bit dibit counter.
- Emission order is in[1:0], in[3:2], in[5:4], in[7:6].
- Accept rule:
  - inclk is accepted when idle=1, or during the cycle that the dibit in[7:6] of the current byte is output.
  - This gives gap-free streaming at one byte per 4 clocks.
  - inclk at any other time is ignored; the current byte is not disturbed.
- States:
  - IDLE (idle=1, outclk=0).
  - SHIFT (dibit index 0..3).
  - SHIFT goes to IDLE after index 3 unless a byte is accepted in that cycle; if one is, it goes to index 0 of the new byte.
- Done handling:
  - done_in sets a pending flag.
  - done_out pulses for one cycle, in the cycle after the shifter is idle with the flag set. The flag then clears.
  - done_in while idle: done_out on the next cycle.
  - done_in and inclk in the same cycle: the byte is emitted first, then done_out.
- CRC:
  - Reflected polynomial 0xEDB88320; initial state 0xFFFFFFFF.
  - Processes 2 bits per outclk, bit out[0] first.
  - crc = bitwise NOT of the state.
  - The state reinitializes to 0xFFFFFFFF on the first outclk of a new frame (the first after reset or after done_out), before absorbing that dibit.
  - crc holds its final value after done_out until the next frame's first dibit.
- idle is registered state, not a combinational look-ahead.

## Timing
- Reset values:
  - out=0, outclk=0, done_out=0, idle=1.
  - crc=0x00000000 (NOT of the initial state).
  - Pending-done flag cleared.
- Latency: inclk sampled at edge N gives dibit 0 with outclk=1 in cycle N+1; dibits 1..3 follow in N+2..N+4.
- Back-to-back: a byte strobed in cycle N+4 gives its dibit 0 in cycle N+5, with no bubble.
- crc reflects a dibit one cycle after that dibit's outclk cycle.
- done_out comes one cycle after idle rises (or the next cycle if done_in arrives while already idle).
- An asynchronous reset mid-byte aborts immediately. All outputs go to their reset values and no done_out is produced.

## Structure
- Shared package (params.vh): BYTE_LEN, CRC32_POLY_REFLECTED=0xEDB88320, CRC32_INIT=0xFFFFFFFF, clog2 function.
- Sub-module crc32 holds the 2-bit-per-cycle reflected CRC update.
  - Ports: clk, reset, clear, inclk, in[1:0], out[31:0].
  - The same module is reusable on the RX side.
- The serializer FSM lives in bytes_to_dibits.

## Test plan
- Single byte 0xD5 strobed once:
  - Dibits 01,01,01,11 in 4 consecutive cycles, with outclk high for those 4 cycles only.
  - idle drops for exactly 4 cycles.
- Bytes "123456789" at one every 4 clocks, then done_in:
  - 36 contiguous outclk cycles.
  - done_out once.
  - crc=0xCBF43926.
  - A second identical frame again yields 0xCBF43926.
- inclk asserted at dibit index 1 of a busy byte: ignored; the current byte's output is unchanged and no extra dibits appear.
- done_in with no data while idle: done_out the next cycle; crc unchanged.
- Reset after 2 dibits of 0xAA:
  - Outputs return to reset values immediately.
  - After release, 0x55 serializes cleanly as 01,01,01,01.
- Simultaneous inclk 0xFF and done_in:
  - Four dibits 11.
  - done_out one cycle after the last one.
  - crc equals the CRC-32 of the single byte 0xFF (0xFF000000).

Source files
------------

// File: rtl/bytes_to_dibits_pkg.sv
// Shared constants and helpers for the RMII byte/dibit datapath and its CRC-32.
package bytes_to_dibits_pkg;

  localparam int BYTE_LEN = 8;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int DIBITS = BYTE_LEN / 2;
  localparam int CNT_W = clog2(DIBITS);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Reflected CRC-32, two bits per call, d[0] absorbed first.
  function automatic logic [31:0] crc32_dibit(input logic [31:0] s, input logic [1:0] d);
    logic [31:0] c;
    c = s;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC32_POLY_REFLECTED;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/bytes_to_dibits_crc32.sv
// Two-bit-per-cycle reflected Ethernet CRC-32; shared between RMII TX and RX paths.
module crc32
  import bytes_to_dibits_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inclk,
  input  logic [1:0]  in,
  output logic [31:0] out
);

  logic [31:0] state_q, state_d;

  // clear restarts the register before the same dibit is absorbed.
  always_comb begin
    state_d = state_q;
    if (inclk) state_d = crc32_dibit(clear ? CRC32_INIT : state_q, in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CRC32_INIT;
    else        state_q <= state_d;
  end

  assign out = ~state_q;

endmodule

// File: rtl/bytes_to_dibits.sv
// Byte-to-dibit serializer for RMII TX, LSB dibit first, with end-of-stream
// passthrough and a running FCS over the emitted dibits.
module bytes_to_dibits
  import bytes_to_dibits_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                inclk,
  input  logic [BYTE_LEN-1:0] in,
  input  logic                done_in,
  output logic [1:0]          out,
  output logic                outclk,
  output logic                idle,
  output logic                done_out,
  output logic [31:0]         crc
);

  ser_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_LEN-1:0] shreg_q, shreg_d;
  logic                pend_q, pend_d;
  logic                done_q, done_d;
  logic                newf_q, newf_d;
  logic                last, accept, fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    last    = (state_q == S_SHIFT) && (cnt_q == CNT_W'(DIBITS - 1));
    accept  = inclk && ((state_q == S_IDLE) || last);
    // The end marker waits until the shifter is idle and no byte is starting.
    fire    = (pend_q || done_in) && (state_q == S_IDLE) && !accept;

    if (accept) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      shreg_d = in;
    end else if (state_q == S_SHIFT) begin
      shreg_d = shreg_q >> 2;
      cnt_d   = cnt_q + 1'b1;
      if (last) state_d = S_IDLE;
    end

    pend_d = fire ? 1'b0 : (pend_q || done_in);
    done_d = fire;
    newf_d = fire ? 1'b1 : ((state_q == S_SHIFT) ? 1'b0 : newf_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      newf_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      newf_q  <= newf_d;
    end
  end

  assign out      = shreg_q[1:0];
  assign outclk   = (state_q == S_SHIFT);
  assign idle     = (state_q == S_IDLE);
  assign done_out = done_q;

  crc32 u_crc (
    .clk   (clk),
    .reset (reset),
    .clear (newf_q && outclk),
    .inclk (outclk),
    .in    (out),
    .out   (crc)
  );

endmodule

// File: tb/tb_bytes_to_dibits.sv
// Scoreboard bench for bytes_to_dibits: expected dibits queued at drive time, popped on outclk.
module tb_bytes_to_dibits;

  logic        clk = 1'b0;
  logic        reset;
  logic        inclk;
  logic [7:0]  in_b;
  logic        done_in;
  logic [1:0]  out;
  logic        outclk;
  logic        idle;
  logic        done_out;
  logic [31:0] crc;

  bytes_to_dibits dut (
    .clk      (clk),
    .reset    (reset),
    .inclk    (inclk),
    .in       (in_b),
    .done_in  (done_in),
    .out      (out),
    .outclk   (outclk),
    .idle     (idle),
    .done_out (done_out),
    .crc      (crc)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int oc_cnt, idle_low, done_cnt, first_oc, last_oc, done_cyc;
  logic [1:0] exp_q[$];
  logic [7:0] fb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_fb();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (fb[i]) begin
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ fb[i][j]) c = (c >> 1) ^ 32'hEDB88320;
        else                 c = c >> 1;
      end
    end
    return ~c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (outclk) begin
        if (oc_cnt == 0) first_oc = cyc;
        last_oc = cyc;
        oc_cnt++;
        if (exp_q.size() == 0) chk("dibit_unexpected", 32'(exp_q.size()), 32'd1);
        else                   chk("dibit", {30'b0, out}, {30'b0, exp_q.pop_front()});
      end
      if (!idle) idle_low++;
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clr_stats();
    oc_cnt = 0; idle_low = 0; done_cnt = 0;
    first_oc = 0; last_oc = 0; done_cyc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
    fb.push_back(b);
  endtask

  task automatic send(input logic [7:0] b);
    inclk = 1'b1;
    in_b  = b;
    push_byte(b);
    tick();
    inclk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; inclk = 1'b0; done_in = 1'b0; in_b = 8'h00;
    clr_stats();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {30'b0, out}, 32'd0);
    chk("rst_outclk", {31'b0, outclk}, 32'd0);
    chk("rst_done", {31'b0, done_out}, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_crc", crc, 32'h00000000);
    @(posedge clk); #1 reset = 1'b1;
    tick();

    // single byte
    clr_stats(); fb.delete();
    send(8'hD5);
    repeat (3) tick();
    chk("d5_outclk_cycles", 32'(oc_cnt), 32'd4);
    chk("d5_idle_low", 32'(idle_low), 32'd4);
    chk("d5_queue_empty", 32'(exp_q.size()), 32'd0);
    pulse_done();
    @(negedge clk);
    chk("d5_done_next", {31'b0, done_out}, 32'd1);
    tick();
    chk("d5_done_once", 32'(done_cnt), 32'd1);

    // "123456789" twice, each closed by done_in
    for (int rep = 0; rep < 2; rep++) begin
      clr_stats(); fb.delete();
      for (int i = 0; i < 9; i++) send(8'h31 + 8'(i));
      pulse_done();
      repeat (4) tick();
      chk("str_outclk_cycles", 32'(oc_cnt), 32'd36);
      chk("str_contiguous", 32'(last_oc - first_oc + 1), 32'd36);
      chk("str_done_once", 32'(done_cnt), 32'd1);
      chk("str_done_lag", 32'(done_cyc - last_oc), 32'd2);
      chk("str_crc_const", crc, 32'hCBF43926);
      chk("str_crc_model", crc, crc_fb());
    end

    // inclk during dibit index 1 is ignored
    clr_stats(); fb.delete();
    inclk = 1'b1; in_b = 8'h3C; push_byte(8'h3C);
    tick();
    inclk = 1'b0;
    tick();
    inclk = 1'b1; in_b = 8'hC3;
    tick();
    inclk = 1'b0;
    repeat (4) tick();
    chk("busy_outclk_cycles", 32'(oc_cnt), 32'd4);
    chk("busy_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("busy_crc", crc, crc_fb());
    pulse_done();
    @(negedge clk);
    chk("busy_done", {31'b0, done_out}, 32'd1);
    tick();

    // done_in with no data while idle
    clr_stats();
    pulse_done();
    @(negedge clk);
    chk("idle_done_next", {31'b0, done_out}, 32'd1);
    chk("idle_crc_hold", crc, crc_fb());
    tick();
    @(negedge clk);
    chk("idle_done_single", {31'b0, done_out}, 32'd0);
    chk("idle_no_dibits", 32'(oc_cnt), 32'd0);
    tick();

    // reset after two dibits of 0xAA
    clr_stats(); fb.delete();
    inclk = 1'b1; in_b = 8'hAA; push_byte(8'hAA);
    @(posedge clk); #1;
    inclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_dibits", 32'(oc_cnt), 32'd2);
    reset = 1'b0;
    #1;
    chk("mid_rst_outclk", {31'b0, outclk}, 32'd0);
    chk("mid_rst_out", {30'b0, out}, 32'd0);
    chk("mid_rst_idle", {31'b0, idle}, 32'd1);
    chk("mid_rst_crc", crc, 32'h00000000);
    exp_q.delete();
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    clr_stats(); fb.delete();
    send(8'h55);
    repeat (3) tick();
    chk("post_rst_outclk_cycles", 32'(oc_cnt), 32'd4);
    chk("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("post_rst_crc", crc, crc_fb());
    pulse_done();
    repeat (3) tick();

    // simultaneous byte and done_in
    clr_stats(); fb.delete();
    inclk = 1'b1; done_in = 1'b1; in_b = 8'hFF; push_byte(8'hFF);
    tick();
    inclk = 1'b0; done_in = 1'b0;
    repeat (7) tick();
    chk("ff_outclk_cycles", 32'(oc_cnt), 32'd4);
    chk("ff_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ff_done_once", 32'(done_cnt), 32'd1);
    chk("ff_done_lag", 32'(done_cyc - last_oc), 32'd2);
    chk("ff_crc_const", crc, 32'hFF000000);
    chk("ff_crc_model", crc, crc_fb());

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
